// File: rtl/phase_controller_if.sv
// ---------------------------------------------------------------------------
// phase_controller_if
//   Bundles the instruction-sequencing signals of phase_controller.
//   master : the block driving exec/step/instr and observing status/decode.
//   slave  : the phase_controller itself.
//   Signals:
//     exec, step, instr            -> toward the controller
//     phase, phase_bus             <- current phase (binary and one-hot)
//     running, halted              <- state flags
//     RegWrite .. PCSrc            <- registered decode of the instruction
//     wb_strobe                    <- write-back enable
//     icount                       <- completed instruction count
// ---------------------------------------------------------------------------
interface phase_controller_if #(
    parameter int NPHASE = 5,
    parameter int IW     = 16,
    parameter int CW     = 16
) ();
    localparam int PW = (NPHASE > 2) ? $clog2(NPHASE) : 1;

    logic              exec;
    logic              step;
    logic [IW-1:0]     instr;
    logic [PW-1:0]     phase;
    logic [NPHASE-1:0] phase_bus;
    logic              running;
    logic              halted;
    logic              RegWrite;
    logic              MemtoReg;
    logic              RegDst;
    logic              ALUSrc;
    logic              PCSrc;
    logic              wb_strobe;
    logic [CW-1:0]     icount;

    modport master (
        output exec, step, instr,
        input  phase, phase_bus, running, halted,
        input  RegWrite, MemtoReg, RegDst, ALUSrc, PCSrc,
        input  wb_strobe, icount
    );

    modport slave (
        input  exec, step, instr,
        output phase, phase_bus, running, halted,
        output RegWrite, MemtoReg, RegDst, ALUSrc, PCSrc,
        output wb_strobe, icount
    );
endinterface

// File: rtl/phase_controller.sv
// ---------------------------------------------------------------------------
// phase_controller
//   Sequences each instruction through NPHASE phases, decodes the instruction
//   presented in phase 0 into registered control signals, and counts completed
//   instructions (saturating).
//   Ports:
//     clock  : sole clock, rising edge
//     reset  : asynchronous, active-low
//     bus    : phase_controller_if.slave (exec/step/instr in; phase,
//              phase_bus, running, halted, decode outputs, wb_strobe,
//              icount out)
// ---------------------------------------------------------------------------
module phase_controller #(
    parameter int NPHASE = 5,
    parameter int IW     = 16,
    parameter int CW     = 16
) (
    input  logic              clock,
    input  logic              reset,
    phase_controller_if.slave bus
);
    localparam int            PW   = (NPHASE > 2) ? $clog2(NPHASE) : 1;
    localparam logic [PW-1:0] LAST = PW'(NPHASE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic regdst;
        logic alusrc;
        logic pcsrc;
        logic hlt;
    } ctrl_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] phase_q;
    ctrl_t         ctrl_q;
    logic          stop_req;
    logic [CW-1:0] icount_q;

    logic in_run;
    logic at_first;
    logic at_last;

    // Only the low 16 bits carry opcode fields, whatever IW is.
    function automatic ctrl_t decode(input logic [15:0] i);
        ctrl_t      c;
        logic [1:0] op1;
        logic [2:0] op2;
        logic [3:0] op3;
        op1 = i[15:14];
        op2 = i[13:11];
        op3 = i[7:4];
        c.regwrite = (i != 16'h0000) &&
                     ((op1 == 2'b00) ||
                      ((op1 == 2'b11) && !(op3 == 4'b0101 || op3 == 4'b1101 ||
                                           op3 == 4'b1111)) ||
                      ((op1 == 2'b10) && (op2 == 3'b000)));
        c.memtoreg = (op1 == 2'b00) || (op1 == 2'b10);
        c.regdst   = (op1 != 2'b00);
        c.alusrc   = (op3[3:2] == 2'b10);
        c.pcsrc    = (op1 == 2'b10) && ((op2 == 3'b100) || (op2 == 3'b111));
        c.hlt      = (op1 == 2'b11) && (op3 == 4'b1111);
        return c;
    endfunction

    // The counter sticks at all-ones rather than wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
    endfunction

    assign in_run   = (state == RUN);
    assign at_first = in_run && (phase_q == '0);
    assign at_last  = in_run && (phase_q == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.exec) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Halt wins over any stop/step request at the instruction end.
                if (phase_q == LAST) begin
                    if (ctrl_q.hlt) begin
                        state_nxt = HALTED;
                    end else if (stop_req || bus.exec || bus.step) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q  <= '0;
            ctrl_q   <= '0;
            stop_req <= 1'b0;
            icount_q <= '0;
        end else begin
            // Phase only advances inside RUN; every other path lands on 0.
            if (in_run && (phase_q != LAST)) begin
                phase_q <= phase_q + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                phase_q <= '0;
            end

            // Decode is captured once per instruction and held afterwards,
            // including while idle or halted.
            if (at_first) begin
                ctrl_q <= decode(bus.instr[15:0]);
            end

            if (state_nxt != RUN) begin
                stop_req <= 1'b0;
            end else if (in_run && bus.exec) begin
                stop_req <= 1'b1;
            end

            if (at_last) begin
                icount_q <= sat_inc(icount_q);
            end
        end
    end

    assign bus.phase     = phase_q;
    assign bus.phase_bus = in_run ? (NPHASE'(1) << phase_q) : '0;
    assign bus.running   = in_run;
    assign bus.halted    = (state == HALTED);
    assign bus.RegWrite  = ctrl_q.regwrite;
    assign bus.MemtoReg  = ctrl_q.memtoreg;
    assign bus.RegDst    = ctrl_q.regdst;
    assign bus.ALUSrc    = ctrl_q.alusrc;
    assign bus.PCSrc     = ctrl_q.pcsrc;
    assign bus.wb_strobe = ctrl_q.regwrite && at_last;
    assign bus.icount    = icount_q;

endmodule

// File: tb/tb_phase_controller.sv
// ---------------------------------------------------------------------------
// tb_phase_controller
//   Directed bench for phase_controller. DUT a: NPHASE=5, CW=16.
//   DUT b: NPHASE=5, CW=3 for counter saturation. Inputs change 1 time unit
//   after a rising edge; outputs are observed at that same point.
// ---------------------------------------------------------------------------
module tb_phase_controller;
    logic clock;
    logic reset;
    int   errors;
    int   checks;

    phase_controller_if #(.NPHASE(5), .IW(16), .CW(16)) ifa ();
    phase_controller_if #(.NPHASE(5), .IW(16), .CW(3))  ifb ();

    phase_controller #(.NPHASE(5), .IW(16), .CW(16)) u_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    phase_controller #(.NPHASE(5), .IW(16), .CW(3)) u_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++; if (ifa.running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b want 0", ifa.running); end
        checks++; if (ifa.phase_bus !== 5'b0) begin errors++; $display("FAIL rst_bus: got %b want 00000", ifa.phase_bus); end
        checks++; if (ifa.icount !== 16'd0) begin errors++; $display("FAIL rst_icount: got %0d want 0", ifa.icount); end
        checks++; if (ifa.RegWrite !== 1'b0) begin errors++; $display("FAIL rst_regwrite: got %b want 0", ifa.RegWrite); end
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (ifa.running !== 1'b0 || ifa.halted !== 1'b0) begin errors++; $display("FAIL idle_no_exec: got run=%b hlt=%b want 0 0", ifa.running, ifa.halted); end
        checks++; if (ifa.phase !== 3'd0) begin errors++; $display("FAIL idle_phase: got %0d want 0", ifa.phase); end
    endtask

    task automatic test_ld();
        logic [4:0] bus_exp;
        logic       wb_exp;
        ifa.instr = 16'h0123;
        ifa.exec  = 1'b1;
        tick();
        ifa.exec  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus_exp = 5'b00001 << k;
            wb_exp  = (k == 4);
            checks++; if (ifa.phase !== 3'(k)) begin errors++; $display("FAIL ld_phase: got %0d want %0d", ifa.phase, k); end
            checks++; if (ifa.phase_bus !== bus_exp) begin errors++; $display("FAIL ld_bus: got %b want %b", ifa.phase_bus, bus_exp); end
            checks++; if (ifa.wb_strobe !== wb_exp) begin errors++; $display("FAIL ld_wb phase %0d: got %b want %b", k, ifa.wb_strobe, wb_exp); end
            if (k == 1) begin
                checks++; if ({ifa.RegWrite, ifa.MemtoReg, ifa.RegDst, ifa.PCSrc} !== 4'b1100) begin errors++; $display("FAIL ld_decode: got %b want 1100", {ifa.RegWrite, ifa.MemtoReg, ifa.RegDst, ifa.PCSrc}); end
            end
            tick();
        end
        checks++; if (ifa.running !== 1'b1 || ifa.phase !== 3'd0) begin errors++; $display("FAIL ld_wrap: got run=%b ph=%0d want 1 0", ifa.running, ifa.phase); end
        checks++; if (ifa.icount !== 16'd1) begin errors++; $display("FAIL ld_icount: got %0d want 1", ifa.icount); end
        ifa.exec = 1'b1;
        tick();
        ifa.exec = 1'b0;
        repeat (4) tick();
        checks++; if (ifa.running !== 1'b0 || ifa.icount !== 16'd2) begin errors++; $display("FAIL ld_stop: got run=%b icount=%0d want 0 2", ifa.running, ifa.icount); end
    endtask

    task automatic test_stop_phase4();
        ifa.instr = 16'h0080;
        ifa.exec  = 1'b1;
        tick();
        ifa.exec  = 1'b0;
        tick();
        checks++; if (ifa.ALUSrc !== 1'b1 || ifa.RegWrite !== 1'b1) begin errors++; $display("FAIL s4_decode: got alusrc=%b rw=%b want 1 1", ifa.ALUSrc, ifa.RegWrite); end
        tick();
        tick();
        tick();
        checks++; if (ifa.running !== 1'b1 || ifa.phase !== 3'd4) begin errors++; $display("FAIL s4_ph4: got run=%b ph=%0d want 1 4", ifa.running, ifa.phase); end
        ifa.exec = 1'b1;
        tick();
        ifa.exec = 1'b0;
        checks++; if (ifa.running !== 1'b0 || ifa.phase !== 3'd0) begin errors++; $display("FAIL s4_idle: got run=%b ph=%0d want 0 0", ifa.running, ifa.phase); end
        checks++; if (ifa.icount !== 16'd3) begin errors++; $display("FAIL s4_icount: got %0d want 3", ifa.icount); end
        checks++; if (ifa.RegWrite !== 1'b1 || ifa.ALUSrc !== 1'b1) begin errors++; $display("FAIL s4_hold: got rw=%b alusrc=%b want 1 1", ifa.RegWrite, ifa.ALUSrc); end
        tick();
        checks++; if (ifa.running !== 1'b0) begin errors++; $display("FAIL s4_stay_idle: got %b want 0", ifa.running); end
    endtask

    task automatic test_stop_phase2();
        ifa.instr = 16'hC050;
        ifa.exec  = 1'b1;
        tick();
        ifa.exec  = 1'b0;
        tick();
        checks++; if (ifa.RegWrite !== 1'b0 || ifa.ALUSrc !== 1'b0) begin errors++; $display("FAIL cmp_decode: got rw=%b alusrc=%b want 0 0", ifa.RegWrite, ifa.ALUSrc); end
        tick();
        ifa.exec = 1'b1;
        tick();
        ifa.exec = 1'b0;
        checks++; if (ifa.running !== 1'b1 || ifa.phase !== 3'd3) begin errors++; $display("FAIL s2_ph3: got run=%b ph=%0d want 1 3", ifa.running, ifa.phase); end
        tick();
        checks++; if (ifa.running !== 1'b1 || ifa.phase !== 3'd4) begin errors++; $display("FAIL s2_ph4: got run=%b ph=%0d want 1 4", ifa.running, ifa.phase); end
        tick();
        checks++; if (ifa.running !== 1'b0 || ifa.icount !== 16'd4) begin errors++; $display("FAIL s2_idle: got run=%b icount=%0d want 0 4", ifa.running, ifa.icount); end
    endtask

    task automatic test_step();
        do_reset();
        ifa.step  = 1'b1;
        ifa.instr = 16'h8000;
        ifa.exec  = 1'b1;
        tick();
        ifa.exec  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (ifa.running !== 1'b1 || ifa.phase !== 3'(k)) begin errors++; $display("FAIL step_run: got run=%b ph=%0d want 1 %0d", ifa.running, ifa.phase, k); end
            if (k == 1) begin
                checks++; if ({ifa.RegWrite, ifa.MemtoReg, ifa.RegDst} !== 3'b111) begin errors++; $display("FAIL li_decode: got %b want 111", {ifa.RegWrite, ifa.MemtoReg, ifa.RegDst}); end
            end
            tick();
        end
        checks++; if (ifa.running !== 1'b0 || ifa.icount !== 16'd1) begin errors++; $display("FAIL step_idle: got run=%b icount=%0d want 0 1", ifa.running, ifa.icount); end
        tick();
        checks++; if (ifa.running !== 1'b0) begin errors++; $display("FAIL step_stay: got %b want 0", ifa.running); end
        ifa.step = 1'b0;
    endtask

    task automatic test_hlt();
        ifa.instr = 16'hC0F0;
        ifa.exec  = 1'b1;
        tick();
        ifa.exec  = 1'b0;
        tick();
        checks++; if ({ifa.RegWrite, ifa.MemtoReg, ifa.RegDst} !== 3'b001) begin errors++; $display("FAIL hlt_decode: got %b want 001", {ifa.RegWrite, ifa.MemtoReg, ifa.RegDst}); end
        repeat (3) tick();
        tick();
        checks++; if (ifa.halted !== 1'b1 || ifa.running !== 1'b0) begin errors++; $display("FAIL hlt_state: got hlt=%b run=%b want 1 0", ifa.halted, ifa.running); end
        checks++; if (ifa.phase_bus !== 5'b0 || ifa.phase !== 3'd0) begin errors++; $display("FAIL hlt_phase: got bus=%b ph=%0d want 00000 0", ifa.phase_bus, ifa.phase); end
        checks++; if (ifa.icount !== 16'd2) begin errors++; $display("FAIL hlt_icount: got %0d want 2", ifa.icount); end
        ifa.exec = 1'b1;
        tick();
        tick();
        ifa.exec = 1'b0;
        ifa.step = 1'b1;
        tick();
        ifa.step = 1'b0;
        tick();
        checks++; if (ifa.halted !== 1'b1 || ifa.running !== 1'b0 || ifa.icount !== 16'd2) begin errors++; $display("FAIL hlt_sticky: got hlt=%b run=%b icount=%0d want 1 0 2", ifa.halted, ifa.running, ifa.icount); end
    endtask

    task automatic test_midop_reset();
        do_reset();
        checks++; if (ifa.halted !== 1'b0) begin errors++; $display("FAIL reset_exit_hlt: got %b want 0", ifa.halted); end
        ifa.instr = 16'h0123;
        ifa.step  = 1'b1;
        ifa.exec  = 1'b1;
        tick();
        ifa.exec  = 1'b0;
        repeat (5) tick();
        ifa.step  = 1'b0;
        checks++; if (ifa.icount !== 16'd1) begin errors++; $display("FAIL mid_pre_icount: got %0d want 1", ifa.icount); end
        ifa.exec = 1'b1;
        tick();
        ifa.exec = 1'b0;
        repeat (3) tick();
        checks++; if (ifa.phase !== 3'd3 || ifa.RegWrite !== 1'b1) begin errors++; $display("FAIL mid_ph3: got ph=%0d rw=%b want 3 1", ifa.phase, ifa.RegWrite); end
        reset = 1'b0;
        #1;
        checks++; if (ifa.running !== 1'b0 || ifa.phase !== 3'd0 || ifa.phase_bus !== 5'b0) begin errors++; $display("FAIL mid_async: got run=%b ph=%0d bus=%b want 0 0 00000", ifa.running, ifa.phase, ifa.phase_bus); end
        checks++; if ({ifa.RegWrite, ifa.MemtoReg} !== 2'b00 || ifa.icount !== 16'd0) begin errors++; $display("FAIL mid_clear: got rw=%b m2r=%b icount=%0d want 0 0 0", ifa.RegWrite, ifa.MemtoReg, ifa.icount); end
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (ifa.running !== 1'b0 || ifa.halted !== 1'b0 || ifa.icount !== 16'd0) begin errors++; $display("FAIL mid_idle: got run=%b hlt=%b icount=%0d want 0 0 0", ifa.running, ifa.halted, ifa.icount); end
    endtask

    task automatic test_saturation();
        logic [2:0] cnt_exp;
        do_reset();
        ifb.instr = 16'h0001;
        ifb.exec  = 1'b1;
        tick();
        ifb.exec  = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            repeat (4) tick();
            checks++; if (ifb.wb_strobe !== 1'b1 || ifb.phase !== 3'd4) begin errors++; $display("FAIL sat_wb: got wb=%b ph=%0d want 1 4", ifb.wb_strobe, ifb.phase); end
            tick();
            cnt_exp = (n > 7) ? 3'd7 : 3'(n);
            checks++; if (ifb.icount !== cnt_exp) begin errors++; $display("FAIL sat_icount %0d: got %0d want %0d", n, ifb.icount, cnt_exp); end
        end
        ifb.instr = 16'h0000;
        for (int k = 1; k < 5; k++) begin
            tick();
            checks++; if (ifb.wb_strobe !== 1'b0) begin errors++; $display("FAIL zero_wb phase %0d: got %b want 0", k, ifb.wb_strobe); end
        end
        checks++; if (ifb.RegWrite !== 1'b0) begin errors++; $display("FAIL zero_regwrite: got %b want 0", ifb.RegWrite); end
        do_reset();
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        ifa.exec  = 1'b0;
        ifa.step  = 1'b0;
        ifa.instr = 16'h0000;
        ifb.exec  = 1'b0;
        ifb.step  = 1'b0;
        ifb.instr = 16'h0000;
        test_reset();
        test_ld();
        test_stop_phase4();
        test_stop_phase2();
        test_step();
        test_hlt();
        test_midop_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/phase_controller.md
PHASE_CONTROLLER -- requirements
Module: phase_controller

Interface
REQ-001 Parameter NPHASE, default 5, phases per instruction; the block SHALL support any NPHASE >= 3.
REQ-002 Parameter IW, default 16, instruction width; IW >= 16, and decode SHALL use instr[15:0] only.
REQ-003 Parameter CW, default 16, instruction-counter width.
REQ-004 Port clock, in, 1, sole clock; all state SHALL update on its rising edge.
REQ-005 Port reset, in, 1, asynchronous, active-low reset.
REQ-006 Port exec, in, 1, start request in IDLE, stop request in RUN.
REQ-007 Port step, in, 1, level; while 1, the block SHALL return to IDLE after each instruction.
REQ-008 Port instr, in, IW, current instruction, valid during phase 0.
REQ-009 Port phase, out, PW = max(1,$clog2(NPHASE)), current phase index.
REQ-010 Port phase_bus, out, NPHASE, one-hot phase (bit k = phase k), all zero outside RUN.
REQ-011 Port running and halted, out, 1 each, state flags.
REQ-012 Ports RegWrite, MemtoReg, RegDst, ALUSrc, PCSrc, out, 1 each, registered decode of the current instruction.
REQ-013 Port wb_strobe, out, 1, write-back enable.
REQ-014 Port icount, out, CW, count of completed instructions.

Function
REQ-015 States SHALL be IDLE, RUN, HALTED; running = (RUN); halted = (HALTED).
REQ-016 IDLE with exec=1 SHALL enter RUN at phase 0 on the next edge; IDLE otherwise holds.
REQ-017 RUN phase SHALL increment by 1 per cycle and wrap NPHASE-1 -> 0.
REQ-018 Field definitions: op1 = instr[15:14], op2 = instr[13:11], op3 = instr[7:4].
REQ-019 Decode rules:
- RegWrite = instr!=0 AND (op1=00 OR (op1=11 AND op3 not in {0101,1101,1111}) OR (op1=10 AND op2=000)).
- MemtoReg = op1 in {00,10}.
- RegDst = op1!=00.
- ALUSrc = op3[3:2]=10.
- PCSrc = op1=10 AND op2 in {100,111}.
- hlt = op1=11 AND op3=1111.
REQ-020 Control outputs and internal hlt SHALL load on the edge leaving phase 0 in RUN; they are visible from phase 1 and held until the next such edge, including through IDLE and HALTED.
REQ-021 wb_strobe SHALL equal RegWrite AND RUN AND phase = NPHASE-1, combinationally.
REQ-022 An exec=1 sample in RUN, in any phase, SHALL set stop_req; stop_req clears on leaving RUN.
REQ-023 On the edge leaving phase NPHASE-1, icount SHALL increment and saturate at all-ones. The next state is chosen by priority:
- hlt -> HALTED.
- else stop_req, or exec=1 on this same edge, or step=1 -> IDLE.
- else phase 0 in RUN.
REQ-024 In IDLE and HALTED, phase SHALL be 0.
REQ-025 HALTED SHALL be exited only by reset; exec and step are ignored in HALTED.
REQ-026 exec held high in IDLE SHALL start exactly one RUN entry per IDLE visit; it has no level-retrigger within RUN beyond stop_req.

Reset
REQ-027 While reset=0, the following SHALL be forced asynchronously to 0: state IDLE, phase, phase_bus, all control outputs, hlt, stop_req, icount.
REQ-028 Reset mid-instruction SHALL discard the instruction; icount is not incremented.
REQ-029 The first RUN entry after reset release SHALL require an exec sample of 1.

Verification (NPHASE=5)
REQ-030 LD flow: reset, exec pulse, instr=16'h0123 -> phase 0,1,2,3,4,0; phase_bus 00001,00010,00100,01000,10000; from phase 1 RegWrite=1, MemtoReg=1, RegDst=0, PCSrc=0; wb_strobe high only in phase 4; icount=1 after the first wrap.
REQ-031 HLT: instr=16'hC0F0 -> RegWrite=0; after phase 4, halted=1, running=0, phase_bus=0; a later exec pulse leaves halted=1 and icount=1.
REQ-032 Step: step=1 plus exec pulse, instr=16'h8000 (LI) -> RegWrite=1, MemtoReg=1, RegDst=1; exactly 5 RUN cycles, then IDLE with icount=1.
REQ-033 Stop request:
- exec pulse in phase 2 -> instruction completes through phase 4, then IDLE.
- exec pulse exactly in phase 4 -> IDLE on the same wrap.
- instr=16'hC050 (CMP) -> RegWrite=0, ALUSrc=0.
REQ-034 Reset mid-op: reset=0 during phase 3 -> all outputs 0 immediately, without a clock edge; icount=0; state IDLE after release.
REQ-035 Saturation, CW=3: run 9 instructions of 16'h0001 -> icount = 1..7, then holds at 7; instr=16'h0000 -> RegWrite=0, wb_strobe never high.
